// File: rtl/fc_l2_arbiter.sv
// Round-robin arbiter sharing the fabric-controller L2 port among N_REQ TCDM requesters,
// with an in-order ID FIFO for response routing. Optional macro: FC_L2_ARB_CORE_PRIO_EN.
module fc_l2_arbiter #(
    parameter int unsigned N_REQ = 5,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     s_req_i,
    input  logic [N_REQ*32-1:0]  s_add_i,
    input  logic [N_REQ-1:0]     s_wen_i,
    input  logic [N_REQ*32-1:0]  s_wdata_i,
    input  logic [N_REQ*4-1:0]   s_be_i,
    output logic [N_REQ-1:0]     s_gnt_o,
    output logic [N_REQ-1:0]     s_r_valid_o,
    output logic [31:0]          s_r_rdata_o,
    output logic                 s_r_opc_o,
    output logic                 m_req_o,
    output logic [31:0]          m_add_o,
    output logic                 m_wen_o,
    output logic [31:0]          m_wdata_o,
    output logic [3:0]           m_be_o,
    input  logic                 m_gnt_i,
    input  logic                 m_r_valid_i,
    input  logic [31:0]          m_r_rdata_i,
    input  logic                 m_r_opc_i,
    output logic                 spurious_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           spurious_q, spurious_d;
    logic [IDW-1:0] fifo_q [DEPTH];

    logic           win_found_s;
    logic [IDW-1:0] win_idx_s;
    logic           core_win_s;
    logic           full_s;
    logic           hs_s;
    logic           pop_s;
    logic [IDW-1:0] head_id_s;

    function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] v);
        if (v == IDW'(N_REQ - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = v + IDW'(1);
        end
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] v);
        if (v == PW'(DEPTH - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = v + PW'(1);
        end
    endfunction

    // Winner search: first pass covers rr_ptr..N_REQ-1, second pass wraps to the lowest index
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        core_win_s  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            win_idx_s   = (!win_found_s && s_req_i[k] && (IDW'(k) >= rr_ptr_q)) ? IDW'(k) : win_idx_s;
            win_found_s = win_found_s | (s_req_i[k] && (IDW'(k) >= rr_ptr_q));
        end
        for (int k = 0; k < N_REQ; k++) begin
            win_idx_s   = (!win_found_s && s_req_i[k]) ? IDW'(k) : win_idx_s;
            win_found_s = win_found_s | s_req_i[k];
        end
`ifdef FC_L2_ARB_CORE_PRIO_EN
        core_win_s = s_req_i[0];
        win_idx_s  = core_win_s ? '0 : win_idx_s;
`else
        core_win_s = 1'b0;
`endif
    end

    assign full_s    = (count_q == CW'(DEPTH));
    assign m_req_o   = (|s_req_i) & ~full_s;
    assign hs_s      = m_req_o & m_gnt_i;
    assign pop_s     = m_r_valid_i & (count_q != '0);
    assign head_id_s = fifo_q[rd_ptr_q];

    assign s_r_rdata_o = m_r_rdata_i;
    assign s_r_opc_o   = m_r_opc_i;
    assign spurious_o  = spurious_q;

    // Payload mux, grant and response routing
    always_comb begin
        m_add_o     = 32'h0000_0000;
        m_wen_o     = 1'b0;
        m_wdata_o   = 32'h0000_0000;
        m_be_o      = 4'b0000;
        s_gnt_o     = '0;
        s_r_valid_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            m_add_o        = (win_found_s && win_idx_s == IDW'(k)) ? s_add_i[k*32 +: 32]   : m_add_o;
            m_wen_o        = (win_found_s && win_idx_s == IDW'(k)) ? s_wen_i[k]            : m_wen_o;
            m_wdata_o      = (win_found_s && win_idx_s == IDW'(k)) ? s_wdata_i[k*32 +: 32] : m_wdata_o;
            m_be_o         = (win_found_s && win_idx_s == IDW'(k)) ? s_be_i[k*4 +: 4]      : m_be_o;
            s_gnt_o[k]     = hs_s & (win_idx_s == IDW'(k));
            s_r_valid_o[k] = pop_s & (head_id_s == IDW'(k));
        end
    end

    // Next-state for priority pointer, ID FIFO pointers/count and spurious flag
    always_comb begin
        rr_ptr_d   = (hs_s && !core_win_s) ? rr_next(win_idx_s) : rr_ptr_q;
        wr_ptr_d   = hs_s  ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop_s ? ptr_next(rd_ptr_q) : rd_ptr_q;
        spurious_d = spurious_q | (m_r_valid_i & (count_q == '0));
        case ({hs_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every outstanding ID
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                fifo_q[k] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            spurious_q <= spurious_d;
            if (hs_s) begin
                fifo_q[wr_ptr_q] <= win_idx_s;
            end
        end
    end

endmodule
